naive_axilite_slave_bridge: RTL and testbench
=============================================

NAIVE_AXILITE_SLAVE_BRIDGE -- requirements
Module: naive_axilite_slave_bridge

Interface
REQ-001 Parameter FAIR_ARB, default 1: 1 = alternate grant when read and write contend; 0 = read always wins.
REQ-002 axi_clk  in  1  sole clock; all logic on rising edge.
REQ-003 axi_reset  in  1  reset is synchronous and active-high.
REQ-004 axi_awaddr in 32, axi_awprot in 3 (ignored), axi_awvalid in 1, axi_awready out 1: write address channel.
REQ-005 axi_wdata in 32, axi_wstrb in 4, axi_wvalid in 1, axi_wready out 1: write data channel.
REQ-006 axi_bresp out 2, axi_bvalid out 1, axi_bready in 1: write response channel.
REQ-007 axi_araddr in 32, axi_arprot in 3 (ignored), axi_arvalid in 1, axi_arready out 1: read address channel.
REQ-008 axi_rdata out 32, axi_rresp out 2, axi_rvalid out 1, axi_rready in 1: read data channel.
REQ-009 bus_en out 1, bus_addr out 32, bus_we out 4 (byte write enables, 0 = read), bus_wdata out 32: shared backend request.
REQ-010 bus_rdata in 32, bus_stall in 1: backend response; an access completes in the cycle bus_en=1 and bus_stall=0, with bus_rdata valid in that cycle.

Function
REQ-011 Write FSM states: W_COLLECT, W_BUS, W_RESP; read FSM states: R_IDLE, R_BUS, R_DATA.
REQ-012 W_COLLECT: awready=1 until AW captured, wready=1 until W captured; AW and W accepted in either order or the same cycle; address/data/strobe registered on handshake.
REQ-013 W_COLLECT -> W_BUS in the cycle after both AW and W are held; a W with wstrb=4'h0 is still a write (bus_we=0 is not issued; the backend access is skipped and the FSM goes directly to W_RESP).
REQ-014 R_IDLE: arready=1; on AR handshake latch araddr, -> R_BUS next cycle.
REQ-015 Ready signals SHALL depend only on registered state, never combinationally on any valid input.
REQ-016 Arbiter: grant taken only when the granted FSM is in *_BUS and bus is idle; grant held until completion (bus_en=1, bus_stall=0); no switching while stalled.
REQ-017 Contention (both in *_BUS, bus idle): FAIR_ARB=1 grants the side not served last (read first after reset); FAIR_ARB=0 grants read.
REQ-018 bus_en=1 exactly while a grant is active; bus_addr/bus_we/bus_wdata from granted side's registers; for reads bus_we=0, bus_wdata=0.
REQ-019 Write completion -> W_RESP next cycle: bvalid=1, bresp=2'b00; held stable until bready; -> W_COLLECT cycle after handshake.
REQ-020 Read completion: bus_rdata registered into axi_rdata, -> R_DATA next cycle: rvalid=1, rresp=2'b00; rdata stable until rready; -> R_IDLE cycle after handshake.
REQ-021 Minimum latency: AR handshake at cycle N, no stall -> bus_en at N+1, rvalid at N+2; write AW+W at N -> bus_en N+1, bvalid N+2.
REQ-022 One outstanding transaction per direction; a new AR/AW/W is not accepted until the prior response handshake completes.
REQ-023 Read and write FSMs progress independently except for the shared bus; a pending B or R response never blocks the other direction.

Reset
REQ-024 On axi_reset=1 at a clock edge: both FSMs to W_COLLECT/R_IDLE, captured flags cleared, grant cleared, fairness pointer to "read first".
REQ-025 Output values during and after reset: awready=wready=arready=1 only from first cycle after reset deassert (0 while axi_reset=1); bvalid=rvalid=0; bus_en=0; bus_we=0; bresp=rresp=2'b00; axi_rdata=0.
REQ-026 Reset mid-transaction (including while bus_stall=1) abandons the transaction; no response is ever issued for it.

Verification
REQ-027 Read, no stall: AR 0x0000_0040, bus_rdata=0xDEAD_BEEF -> bus_en one cycle with addr 0x40, we=0; rvalid two cycles after AR, rdata=0xDEADBEEF, rresp=0.
REQ-028 Write, W before AW: W 0x1234_5678 strb 4'b0011 at cycle 0, AW 0x80 at cycle 3 -> bus_en at cycle 4, we=4'b0011, wdata=0x12345678; bvalid at cycle 5.
REQ-029 Stall and backpressure: read with bus_stall=1 for 3 cycles, rready low 4 cycles -> bus_en held 4 cycles with stable addr; rdata stable while rvalid and rready low.
REQ-030 Contention, FAIR_ARB=1: read and write enter *_BUS same cycle twice in a row -> first grant read, second grant write; FAIR_ARB=0 -> read both times.
REQ-031 Reset asserted while bus_stall=1 mid-write -> bus_en=0 next cycle, bvalid never asserted, next write completes normally.
REQ-032 Zero-strobe write: strb=0, AW 0x10 -> no bus_en cycle, bvalid one cycle after capture, bresp=0.

Source files
------------

// File: rtl/naive_axilite_slave_bridge.sv
// naive_axilite_slave_bridge
//
// AXI4-Lite slave that turns one read and one write transaction at a time
// into accesses on a single shared backend bus. The read and write
// directions are independent FSMs that only meet at the bus arbiter.
//
// Ports
//   axi_clk, axi_reset      clock (rising edge), synchronous active-high reset
//   axi_aw*, axi_w*, axi_b* AXI4-Lite write address / data / response
//   axi_ar*, axi_r*         AXI4-Lite read address / data
//   bus_en, bus_addr,       backend request; bus_we is a byte-enable mask,
//   bus_we, bus_wdata       all zero for reads
//   bus_rdata, bus_stall    backend response; an access completes in a cycle
//                           with bus_en=1 and bus_stall=0
//
// Parameter FAIR_ARB: 1 = alternate the winner when both sides contend,
//                     0 = read always wins.
//
// State           | meaning
// W_COLLECT       | accepting AW and W in any order, holding whichever arrived
// W_BUS           | write waiting for / owning the backend bus
// W_RESP          | B response presented, waiting for bready
// R_IDLE          | accepting AR
// R_BUS           | read waiting for / owning the backend bus
// R_DATA          | R response presented, waiting for rready

module naive_axilite_slave_bridge #(
    parameter int unsigned FAIR_ARB = 1
) (
    input  logic        axi_clk,
    input  logic        axi_reset,

    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_awvalid,
    output logic        axi_awready,

    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,

    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,

    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    input  logic        axi_arvalid,
    output logic        axi_arready,

    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,

    output logic        bus_en,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_stall
);

    typedef enum logic [1:0] {W_COLLECT, W_BUS, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_BUS, R_DATA} r_state_t;

    w_state_t    w_state_q, w_state_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    r_state_t    r_state_q, r_state_d;
    logic [31:0] raddr_q, raddr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        busy_q, busy_d;         // grant held across a stall
    logic        owner_wr_q, owner_wr_d; // which side holds the stalled grant
    logic        rd_first_q, rd_first_d; // next contention goes to read

    logic        gnt_rd, gnt_wr;
    logic        aw_hs, w_hs, ar_hs;

    // prot bits carry no meaning for this backend
    logic        unused_prot;
    assign unused_prot = ^{axi_awprot, axi_arprot};

    // Readies come from registered state only; they are additionally held low
    // while reset is asserted so nothing is accepted during reset.
    assign axi_awready = (w_state_q == W_COLLECT) && !aw_held_q && !axi_reset;
    assign axi_wready  = (w_state_q == W_COLLECT) && !w_held_q  && !axi_reset;
    assign axi_arready = (r_state_q == R_IDLE) && !axi_reset;

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid  && axi_wready;
    assign ar_hs = axi_arvalid && axi_arready;

    assign axi_bvalid = (w_state_q == W_RESP);
    assign axi_bresp  = 2'b00;
    assign axi_rvalid = (r_state_q == R_DATA);
    assign axi_rresp  = 2'b00;
    assign axi_rdata  = rdata_q;

    // Arbiter. A fresh grant is decided combinationally in the first BUS
    // cycle so the access starts without an extra cycle; once a stall is
    // seen the owner is latched and kept until the access completes. The
    // fairness pointer only moves when both sides actually contend.
    always_comb begin
        gnt_rd     = 1'b0;
        gnt_wr     = 1'b0;
        rd_first_d = rd_first_q;
        if (busy_q) begin
            gnt_rd = !owner_wr_q;
            gnt_wr = owner_wr_q;
        end else if ((r_state_q == R_BUS) && (w_state_q == W_BUS)) begin
            if ((FAIR_ARB != 0) && !rd_first_q) begin
                gnt_wr = 1'b1;
            end else begin
                gnt_rd = 1'b1;
            end
            rd_first_d = gnt_wr;
        end else begin
            gnt_rd = (r_state_q == R_BUS);
            gnt_wr = (w_state_q == W_BUS);
        end
    end

    assign bus_en     = gnt_rd || gnt_wr;
    assign bus_addr   = gnt_wr ? waddr_q : (gnt_rd ? raddr_q : 32'h0);
    assign bus_we     = gnt_wr ? wstrb_q : 4'h0;
    assign bus_wdata  = gnt_wr ? wdata_q : 32'h0;
    assign busy_d     = bus_en && bus_stall;
    assign owner_wr_d = gnt_wr;

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (aw_hs) begin
            waddr_d = axi_awaddr;
        end
        if (w_hs) begin
            wdata_d = axi_wdata;
            wstrb_d = axi_wstrb;
        end
        case (w_state_q)
            W_COLLECT: begin
                aw_held_d = aw_held_q || aw_hs;
                w_held_d  = w_held_q  || w_hs;
                if (aw_held_d && w_held_d) begin
                    // an all-zero strobe writes nothing, so skip the bus
                    w_state_d = (wstrb_d == 4'h0) ? W_RESP : W_BUS;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            W_BUS: begin
                if (gnt_wr && !bus_stall) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi_bready) begin
                    w_state_d = W_COLLECT;
                end
            end
            default: w_state_d = W_COLLECT;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    raddr_d   = axi_araddr;
                    r_state_d = R_BUS;
                end
            end
            R_BUS: begin
                if (gnt_rd && !bus_stall) begin
                    rdata_d   = bus_rdata;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            w_state_q  <= W_COLLECT;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            waddr_q    <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            r_state_q  <= R_IDLE;
            raddr_q    <= 32'h0;
            rdata_q    <= 32'h0;
            busy_q     <= 1'b0;
            owner_wr_q <= 1'b0;
            rd_first_q <= 1'b1;
        end else begin
            w_state_q  <= w_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            r_state_q  <= r_state_d;
            raddr_q    <= raddr_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            owner_wr_q <= owner_wr_d;
            rd_first_q <= rd_first_d;
        end
    end

endmodule

// File: tb/tb_naive_axilite_slave_bridge.sv
module tb_naive_axilite_slave_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
    logic [31:0] bus_rdata;
    logic        bus_stall;

    logic        awready, wready, bvalid, arready, rvalid, bus_en;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_we;

    logic        z_awready, z_wready, z_bvalid, z_arready, z_rvalid, z_bus_en;
    logic [1:0]  z_bresp, z_rresp;
    logic [31:0] z_rdata, z_bus_addr, z_bus_wdata;
    logic [3:0]  z_bus_we;

    int n_chk  = 0;
    int n_miss = 0;

    naive_axilite_slave_bridge #(.FAIR_ARB(1)) dut (
        .axi_clk(clk), .axi_reset(rst),
        .axi_awaddr(awaddr), .axi_awprot(awprot), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_araddr(araddr), .axi_arprot(arprot), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
        .bus_en(bus_en), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_stall(bus_stall)
    );

    naive_axilite_slave_bridge #(.FAIR_ARB(0)) dut0 (
        .axi_clk(clk), .axi_reset(rst),
        .axi_awaddr(awaddr), .axi_awprot(awprot), .axi_awvalid(awvalid), .axi_awready(z_awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(z_wready),
        .axi_bresp(z_bresp), .axi_bvalid(z_bvalid), .axi_bready(bready),
        .axi_araddr(araddr), .axi_arprot(arprot), .axi_arvalid(arvalid), .axi_arready(z_arready),
        .axi_rdata(z_rdata), .axi_rresp(z_rresp), .axi_rvalid(z_rvalid), .axi_rready(rready),
        .bus_en(z_bus_en), .bus_addr(z_bus_addr), .bus_we(z_bus_we), .bus_wdata(z_bus_wdata),
        .bus_rdata(bus_rdata), .bus_stall(bus_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        awv;
        logic [31:0] awa;
        logic        wv;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        bry;
        logic        arv;
        logic [31:0] ara;
        logic        rry;
        logic [31:0] brd;
        logic        stl;
        logic        e_awr;
        logic        e_wr;
        logic        e_arr;
        logic        e_bv;
        logic        e_rv;
        logic        e_ben;
        logic [31:0] e_addr;
        logic [3:0]  e_we;
        logic [31:0] e_wd;
        logic        c_rd;
        logic [31:0] e_rd;
    } vec_t;

    localparam int NV = 25;
    vec_t tv [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b0; awvalid = 1'b0; awaddr = 32'h0; awprot = 3'h0;
        wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; bready = 1'b0;
        arvalid = 1'b0; araddr = 32'h0; arprot = 3'h0; rready = 1'b0;
        bus_rdata = 32'h0; bus_stall = 1'b0;
    endtask

    initial begin
        //         rst aw  awaddr        w   wdata         strb bry ar  araddr        rry bus_rdata     stl  | awr wr  arr bv  rv  ben addr          we    wdata         crd rdata
        tv[0]  = '{1'b1,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b1,32'h0};
        tv[1]  = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[2]  = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b1,32'h40,    1'b0,32'hDEADBEEF,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[3]  = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'hDEADBEEF,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,32'h40,  4'h0,32'h0,       1'b0,32'h0};
        tv[4]  = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,   4'h0,32'h0,       1'b1,32'hDEADBEEF};
        tv[5]  = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b1,32'h0,       1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,   4'h0,32'h0,       1'b1,32'hDEADBEEF};
        tv[6]  = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[7]  = '{1'b0,1'b0,32'h0,      1'b1,32'h12345678,4'h3,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[8]  = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[9]  = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[10] = '{1'b0,1'b1,32'h80,     1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[11] = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h80,  4'h3,32'h12345678,1'b0,32'h0};
        tv[12] = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[13] = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b1,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[14] = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[15] = '{1'b0,1'b1,32'h10,     1'b1,32'hAAAA5555,4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[16] = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[17] = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b1,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[18] = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[19] = '{1'b0,1'b1,32'h100,    1'b1,32'hCAFEF00D,4'hF,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[20] = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h100, 4'hF,32'hCAFEF00D,1'b0,32'h0};
        tv[21] = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b1,32'h44,    1'b0,32'h11112222,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};
        tv[22] = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h11112222,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'h44,  4'h0,32'h0,       1'b0,32'h0};
        tv[23] = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b1,1'b0,32'h0,     1'b1,32'h0,       1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,   4'h0,32'h0,       1'b1,32'h11112222};
        tv[24] = '{1'b0,1'b0,32'h0,      1'b0,32'h0,       4'h0,1'b0,1'b0,32'h0,     1'b0,32'h0,       1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,       1'b0,32'h0};

        set_idle();
        rst = 1'b1;
        step();
        step();

        for (int i = 0; i < NV; i++) begin
            rst = tv[i].rst; awvalid = tv[i].awv; awaddr = tv[i].awa;
            wvalid = tv[i].wv; wdata = tv[i].wd; wstrb = tv[i].ws; bready = tv[i].bry;
            arvalid = tv[i].arv; araddr = tv[i].ara; rready = tv[i].rry;
            bus_rdata = tv[i].brd; bus_stall = tv[i].stl;
            #1;
            chk($sformatf("v%0d awready", i), 32'(awready), 32'(tv[i].e_awr));
            chk($sformatf("v%0d wready", i),  32'(wready),  32'(tv[i].e_wr));
            chk($sformatf("v%0d arready", i), 32'(arready), 32'(tv[i].e_arr));
            chk($sformatf("v%0d bvalid", i),  32'(bvalid),  32'(tv[i].e_bv));
            chk($sformatf("v%0d rvalid", i),  32'(rvalid),  32'(tv[i].e_rv));
            chk($sformatf("v%0d bus_en", i),  32'(bus_en),  32'(tv[i].e_ben));
            if (tv[i].e_ben) begin
                chk($sformatf("v%0d bus_addr", i),  bus_addr,  tv[i].e_addr);
                chk($sformatf("v%0d bus_wdata", i), bus_wdata, tv[i].e_wd);
            end
            if (tv[i].e_ben || tv[i].rst)
                chk($sformatf("v%0d bus_we", i), 32'(bus_we), 32'(tv[i].e_we));
            if (tv[i].e_bv || tv[i].rst)
                chk($sformatf("v%0d bresp", i), 32'(bresp), 32'h0);
            if (tv[i].e_rv || tv[i].rst)
                chk($sformatf("v%0d rresp", i), 32'(rresp), 32'h0);
            if (tv[i].c_rd)
                chk($sformatf("v%0d rdata", i), rdata, tv[i].e_rd);
            step();
        end

        // Read held off by a 3-cycle stall, then rready held low 4 cycles.
        set_idle();
        arvalid = 1'b1; araddr = 32'h60; bus_stall = 1'b1;
        #1;
        step();
        arvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_stall = (k < 3);
            bus_rdata = (k == 3) ? 32'h5A5A5A5A : (32'hFFFF0000 + 32'(k));
            #1;
            chk($sformatf("stall%0d bus_en", k), 32'(bus_en), 32'h1);
            chk($sformatf("stall%0d bus_addr", k), bus_addr, 32'h60);
            chk($sformatf("stall%0d bus_we", k), 32'(bus_we), 32'h0);
            step();
        end
        bus_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rready = 1'b0;
            bus_rdata = $urandom;
            #1;
            chk($sformatf("bp%0d rvalid", k), 32'(rvalid), 32'h1);
            chk($sformatf("bp%0d rdata", k), rdata, 32'h5A5A5A5A);
            chk($sformatf("bp%0d bus_en", k), 32'(bus_en), 32'h0);
            step();
        end
        rready = 1'b1;
        #1;
        chk("bp rvalid at handshake", 32'(rvalid), 32'h1);
        step();
        rready = 1'b0;
        #1;
        chk("bp rvalid after handshake", 32'(rvalid), 32'h0);
        chk("bp arready after handshake", 32'(arready), 32'h1);

        // Reset while a write is stalled on the bus.
        set_idle();
        awvalid = 1'b1; awaddr = 32'h200; wvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF;
        bus_stall = 1'b1;
        #1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        chk("rstw bus_en stalled", 32'(bus_en), 32'h1);
        chk("rstw bus_addr stalled", bus_addr, 32'h200);
        step();
        rst = 1'b1;
        #1;
        chk("rstw awready in reset", 32'(awready), 32'h0);
        step();
        #1;
        chk("rstw bus_en after reset", 32'(bus_en), 32'h0);
        chk("rstw bus_we after reset", 32'(bus_we), 32'h0);
        rst = 1'b0; bus_stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rstw%0d bvalid", k), 32'(bvalid), 32'h0);
            chk($sformatf("rstw%0d bus_en", k), 32'(bus_en), 32'h0);
            step();
        end
        awvalid = 1'b1; awaddr = 32'h204; wvalid = 1'b1; wdata = 32'h600DCAFE; wstrb = 4'hC;
        #1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        chk("rstw2 bus_en", 32'(bus_en), 32'h1);
        chk("rstw2 bus_addr", bus_addr, 32'h204);
        chk("rstw2 bus_we", 32'(bus_we), 32'hC);
        chk("rstw2 bus_wdata", bus_wdata, 32'h600DCAFE);
        step();
        #1;
        chk("rstw2 bvalid", 32'(bvalid), 32'h1);
        chk("rstw2 bresp", 32'(bresp), 32'h0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        #1;
        chk("rstw2 bvalid cleared", 32'(bvalid), 32'h0);

        // Contention twice in a row, fair and read-priority instances.
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        arvalid = 1'b1; araddr = 32'h300;
        awvalid = 1'b1; awaddr = 32'h304; wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF;
        bus_rdata = 32'h99;
        #1;
        step();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        #1;
        chk("c1 fair bus_en", 32'(bus_en), 32'h1);
        chk("c1 fair bus_we", 32'(bus_we), 32'h0);
        chk("c1 fair bus_addr", bus_addr, 32'h300);
        chk("c1 rdprio bus_en", 32'(z_bus_en), 32'h1);
        chk("c1 rdprio bus_we", 32'(z_bus_we), 32'h0);
        chk("c1 rdprio bus_addr", z_bus_addr, 32'h300);
        bready = 1'b1; rready = 1'b1;
        step();
        #1;
        chk("c1 fair write follows bus_we", 32'(bus_we), 32'hF);
        chk("c1 fair write follows bus_addr", bus_addr, 32'h304);
        step();
        step();
        step();
        bready = 1'b0; rready = 1'b0;
        #1;
        chk("c1 drained awready", 32'(awready), 32'h1);
        chk("c1 drained arready", 32'(z_arready), 32'h1);

        arvalid = 1'b1; araddr = 32'h3F0;
        awvalid = 1'b1; awaddr = 32'h3F4; wvalid = 1'b1; wdata = 32'h88; wstrb = 4'hF;
        #1;
        step();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        #1;
        chk("c2 fair bus_en", 32'(bus_en), 32'h1);
        chk("c2 fair bus_we", 32'(bus_we), 32'hF);
        chk("c2 fair bus_addr", bus_addr, 32'h3F4);
        chk("c2 fair bus_wdata", bus_wdata, 32'h88);
        chk("c2 rdprio bus_en", 32'(z_bus_en), 32'h1);
        chk("c2 rdprio bus_we", 32'(z_bus_we), 32'h0);
        chk("c2 rdprio bus_addr", z_bus_addr, 32'h3F0);
        bready = 1'b1; rready = 1'b1;
        repeat (4) step();
        set_idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
        $finish;
    end

endmodule
